approx_add_arbiter: RTL and testbench

Round-robin arbiter and issue controller that shares a single approximate adder among `N_REQ` requesters, such as systolic-array PE columns or accumulator banks. It grants one requester per cycle over valid/ready handshakes, computes the lower-part-OR approximate sum, and holds the result in one output register tagged with the requester ID. It also keeps a wrapping count of completed results for profiling.

---
 rtl/approx_add_arbiter.sv | 124 ++++++++++++
 tb/tb_approx_add_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_add_arbiter.sv
// Round-robin arbiter sharing one adder (lower-part-OR approximate when APPROX_ADD_EN is defined, exact otherwise).
// Latency: one cycle from grant to res_valid, with one result per cycle sustained.
// Backpressure: a held result (res_valid && !res_ready) blocks all grants; the register refills in the same cycle it drains.
module approx_add_arbiter #(
  parameter int DW_A       = 16,
  parameter int DW_B       = 19,
  parameter int PERCENTAGE = 4,
  parameter int N_REQ      = 4,
  localparam int DW_C      = (DW_A > DW_B) ? DW_A : DW_B,
  localparam int IDW       = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*DW_A-1:0]   req_a,
  input  logic [N_REQ*DW_B-1:0]   req_b,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [DW_C-1:0]         res_data,
  output logic [IDW-1:0]          res_id,
  output logic [15:0]             res_count
);

  // Width of the OR-approximated low part of the sum.
  localparam int L = DW_C / PERCENTAGE;

  // An out-of-range low-part width refers to a module that does not exist, stopping elaboration.
  if (!(L >= 1 && L < DW_C)) begin : g_bad_l
    approx_add_arbiter_illegal_low_width u_bad ();
  end

  logic [IDW-1:0]  ptr_q, ptr_d;
  logic            res_valid_q, res_valid_d;
  logic [DW_C-1:0] res_data_q, res_data_d;
  logic [IDW-1:0]  res_id_q, res_id_d;
  logic [15:0]     res_count_q, res_count_d;

  logic            gnt_vld;
  logic [IDW-1:0]  gnt_idx;
  logic            slot_free;
  logic            fire;
  logic            res_hs;
  logic [DW_C-1:0] a_ext, b_ext, sum;

  assign slot_free = !res_valid_q || res_ready;
  assign res_hs    = res_valid_q && res_ready;

  // Pick the first valid requester at or after ptr, wrapping; lowest offset wins.
  always_comb begin
    int t;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      t = int'(ptr_q) + k;
      if (t >= N_REQ) t = t - N_REQ;
      if (req_valid[t]) begin
        gnt_vld = 1'b1;
        gnt_idx = IDW'(t);
      end
    end
  end

  // Grant only when the output register can take a result; held low during reset.
  assign req_ready = (rst_n && slot_free && gnt_vld) ? (N_REQ'(1) << gnt_idx) : '0;
  assign fire      = |req_ready;

  // Mux the granted operands, zero-extend, and form the sum in the same cycle.
  always_comb begin
    a_ext = '0;
    b_ext = '0;
    a_ext[DW_A-1:0] = req_a[int'(gnt_idx)*DW_A +: DW_A];
    b_ext[DW_B-1:0] = req_b[int'(gnt_idx)*DW_B +: DW_B];
`ifdef APPROX_ADD_EN
    sum = '0;
    sum[L-1:0]      = a_ext[L-1:0] | b_ext[L-1:0];
    // Only the top bit of the low part generates a carry; the final carry out is dropped.
    sum[DW_C-1:L]   = a_ext[DW_C-1:L] + b_ext[DW_C-1:L]
                    + (DW_C-L)'(a_ext[L-1] & b_ext[L-1]);
`else
    sum = a_ext + b_ext;
`endif
  end

  // Next-state for the result register, pointer and profiling counter.
  always_comb begin
    ptr_d       = ptr_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    res_count_d = res_count_q + 16'(res_hs);
    if (fire) begin
      res_valid_d = 1'b1;
      res_data_d  = sum;
      res_id_d    = gnt_idx;
      ptr_d       = (gnt_idx == IDW'(N_REQ - 1)) ? '0 : gnt_idx + IDW'(1);
    end else if (res_hs) begin
      res_valid_d = 1'b0;
    end
  end

  // State registers, all cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
      res_count_q <= '0;
    end else begin
      ptr_q       <= ptr_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
      res_count_q <= res_count_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
  assign res_count = res_count_q;

endmodule

// File: tb/tb_approx_add_arbiter.sv
module tb_approx_add_arbiter;
  localparam int DWA = 16;
  localparam int DWB = 19;
  localparam int DWC = 19;
  localparam int L   = 4;
  localparam int N   = 4;

  logic             clk, rst_n;
  logic [N-1:0]     req_valid, req_ready;
  logic [N*DWA-1:0] req_a;
  logic [N*DWB-1:0] req_b;
  logic             res_valid, res_ready;
  logic [DWC-1:0]   res_data;
  logic [1:0]       res_id;
  logic [15:0]      res_count;

  approx_add_arbiter #(.DW_A(DWA), .DW_B(DWB), .PERCENTAGE(4), .N_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id), .res_count(res_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_fail = 0;

  // stimulus
  logic [DWA-1:0] ta [N];
  logic [DWB-1:0] tbv [N];
  logic [N-1:0]   tv;
  logic           rr;

  // reference model state
  int          m_ptr, m_id, m_cnt;
  bit          m_vld;
  logic [DWC-1:0] m_data;
  int          exp_g;
  logic [N-1:0] obs_rdy, exp_rdy;

  function automatic logic [DWC-1:0] ref_sum(longint a, longint b);
    longint lo, hi, cin;
`ifdef APPROX_ADD_EN
    lo  = (a | b) % (longint'(1) << L);
    cin = (a >> (L-1)) & (b >> (L-1)) & 1;
    hi  = ((a >> L) + (b >> L) + cin) % (longint'(1) << (DWC-L));
    return DWC'(hi * (longint'(1) << L) + lo);
`else
    lo = 0; hi = 0; cin = 0;
    return DWC'((a + b) % (longint'(1) << DWC));
`endif
  endfunction

  function automatic int exp_grant();
    if (m_vld && !rr) return -1;
    for (int k = 0; k < N; k++)
      if (tv[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_id = 0; m_cnt = 0; m_vld = 0; m_data = '0;
  endtask

  task automatic model_step(int g);
    if (m_vld && rr) m_cnt = (m_cnt + 1) % 65536;
    if (g >= 0) begin
      m_data = ref_sum(longint'(ta[g]), longint'(tbv[g]));
      m_id = g; m_vld = 1; m_ptr = (g + 1) % N;
    end else if (m_vld && rr) begin
      m_vld = 0;
    end
  endtask

  // Drive one cycle of stimulus; capture req_ready mid-cycle and advance the model at the edge.
  task automatic run_cycle();
    for (int i = 0; i < N; i++) begin
      req_a[i*DWA +: DWA] = ta[i];
      req_b[i*DWB +: DWB] = tbv[i];
    end
    req_valid = tv;
    res_ready = rr;
    @(negedge clk);
    obs_rdy = req_ready;
    exp_g   = exp_grant();
    exp_rdy = (exp_g >= 0) ? (N'(1) << exp_g) : '0;
    @(posedge clk);
    model_step(exp_g);
    #1;
  endtask

  task automatic rand_operands();
    for (int i = 0; i < N; i++) begin
      ta[i]  = DWA'($urandom);
      tbv[i] = DWB'($urandom);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tv = '1; rr = 1'b1; rand_operands();
    for (int i = 0; i < N; i++) begin
      req_a[i*DWA +: DWA] = ta[i];
      req_b[i*DWB +: DWB] = tbv[i];
    end
    req_valid = tv; res_ready = rr;
    #22;
    n_cmp++;
    if ({req_ready, res_valid, res_data, res_id, res_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: rdy=%b vld=%b data=%h id=%0d cnt=%0d required all zero",
               req_ready, res_valid, res_data, res_id, res_count);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_round_robin();
    int seq [6] = '{0, 1, 2, 3, 0, 1};
    tv = '1; rr = 1'b1;
    for (int c = 0; c < 6; c++) begin
      rand_operands();
      run_cycle();
      n_cmp++;
      if (obs_rdy !== (N'(1) << seq[c])) begin
        n_fail++; $display("FAIL rr_grant[%0d]: got %b required %b", c, obs_rdy, N'(1) << seq[c]);
      end
      n_cmp++;
      if (res_id !== 2'(seq[c]) || res_data !== m_data || res_count !== 16'(c)) begin
        n_fail++;
        $display("FAIL rr_result[%0d]: id=%0d data=%h cnt=%0d required id=%0d data=%h cnt=%0d",
                 c, res_id, res_data, res_count, seq[c], m_data, c);
      end
    end
  endtask

  task automatic test_skip_idle();
    int seq [4] = '{3, 1, 3, 1};
    tv = 4'b1010; rr = 1'b1;
    for (int c = 0; c < 4; c++) begin
      rand_operands();
      run_cycle();
      n_cmp++;
      if (obs_rdy !== (N'(1) << seq[c]) || res_id !== 2'(seq[c])) begin
        n_fail++;
        $display("FAIL skip_idle[%0d]: rdy=%b id=%0d required grant %0d", c, obs_rdy, res_id, seq[c]);
      end
    end
  endtask

  task automatic test_approx_arith();
    logic [DWA-1:0] va [3] = '{16'h000F, 16'h0008, 16'hFFFF};
    logic [DWB-1:0] vb [3] = '{19'h00001, 19'h00008, 19'h7FFFF};
`ifdef APPROX_ADD_EN
    logic [DWC-1:0] vr [3] = '{19'h0000F, 19'h00018, 19'h0FFFF};
`else
    logic [DWC-1:0] vr [3] = '{19'h00010, 19'h00010, 19'h0FFFE};
`endif
    tv = 4'b0001; rr = 1'b1;
    for (int c = 0; c < 3; c++) begin
      rand_operands();
      ta[0] = va[c]; tbv[0] = vb[c];
      run_cycle();
      n_cmp++;
      if (res_data !== vr[c] || res_id !== 2'd0 || res_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL arith[%0d]: data=%h id=%0d vld=%b required data=%h id=0 vld=1",
                 c, res_data, res_id, res_valid, vr[c]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [DWC-1:0] held;
    logic [15:0]    cnt0;
    tv = 4'b0100; rr = 1'b1; rand_operands();
    run_cycle();
    held = res_data; cnt0 = res_count;
    n_cmp++;
    if (res_id !== 2'd2 || held !== m_data) begin
      n_fail++; $display("FAIL bp_capture: id=%0d data=%h required id=2 data=%h", res_id, held, m_data);
    end
    tv = '1; rr = 1'b0;
    for (int c = 0; c < 5; c++) begin
      rand_operands();
      run_cycle();
      n_cmp++;
      if (obs_rdy !== '0 || res_valid !== 1'b1 || res_data !== held || res_id !== 2'd2 || res_count !== cnt0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: rdy=%b vld=%b data=%h id=%0d cnt=%0d required rdy=0 vld=1 data=%h id=2 cnt=%0d",
                 c, obs_rdy, res_valid, res_data, res_id, res_count, held, cnt0);
      end
    end
    rr = 1'b1;
    run_cycle();
    n_cmp++;
    if (obs_rdy !== 4'b1000 || res_valid !== 1'b1 || res_id !== 2'd3 || res_count !== cnt0 + 16'd1
        || res_data !== m_data) begin
      n_fail++;
      $display("FAIL bp_release: rdy=%b vld=%b id=%0d cnt=%0d data=%h required rdy=1000 vld=1 id=3 cnt=%0d data=%h",
               obs_rdy, res_valid, res_id, res_count, res_data, cnt0 + 16'd1, m_data);
    end
  endtask

  task automatic test_reset_mid();
    tv = 4'b0010; rr = 1'b1; rand_operands();
    run_cycle();                       // grant req1 -> ptr becomes 2
    tv = '1; rr = 1'b0;
    run_cycle();                       // held, no grant
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({req_ready, res_valid, res_data, res_id, res_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: rdy=%b vld=%b data=%h id=%0d cnt=%0d required all zero",
               req_ready, res_valid, res_data, res_id, res_count);
    end
    rr = 1'b1; res_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (req_ready !== '0 || res_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_hold: rdy=%b vld=%b required 0", req_ready, res_valid);
    end
    rst_n = 1'b1;
    model_reset();
    rand_operands();
    run_cycle();
    n_cmp++;
    if (obs_rdy !== 4'b0001 || res_id !== 2'd0 || res_valid !== 1'b1 || res_data !== m_data) begin
      n_fail++;
      $display("FAIL reset_first_grant: rdy=%b id=%0d vld=%b data=%h required rdy=0001 id=0 vld=1 data=%h",
               obs_rdy, res_id, res_valid, res_data, m_data);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rand_operands();
      tv = N'($urandom);
      rr = ($urandom_range(0, 3) != 0);
      run_cycle();
      n_cmp++;
      if (obs_rdy !== exp_rdy || res_valid !== m_vld || res_data !== m_data
          || res_id !== 2'(m_id) || res_count !== 16'(m_cnt)) begin
        n_fail++;
        $display("FAIL random[%0d]: rdy=%b vld=%b data=%h id=%0d cnt=%0d required rdy=%b vld=%b data=%h id=%0d cnt=%0d",
                 c, obs_rdy, res_valid, res_data, res_id, res_count,
                 exp_rdy, m_vld, m_data, m_id, m_cnt);
      end
    end
  endtask

  task automatic test_count_wrap();
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    model_reset();
    tv = 4'b0001; rr = 1'b1;
    for (int k = 0; k <= 65536; k++) begin
      run_cycle();
      if (k == 65535) begin
        n_cmp++;
        if (res_count !== 16'hFFFF) begin
          n_fail++; $display("FAIL count_max: got %0d required 65535", res_count);
        end
      end
    end
    n_cmp++;
    if (res_count !== 16'd0 || res_valid !== 1'b1) begin
      n_fail++; $display("FAIL count_wrap: cnt=%0d vld=%b required cnt=0 vld=1", res_count, res_valid);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_skip_idle();
    test_approx_arith();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_count_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
